i2c_write_master: RTL and testbench
===================================

# i2c_write_master

Single-master I2C write engine that serialises one 3-byte transaction {slave address, sub-address, data} onto SCL/SDA. It sits directly downstream of the HDMI transmitter configuration sequencer: the sequencer presents a 24-bit word and a GO request, and this block reports completion and acknowledge status. Everything runs in the iCLK domain, with an internal quarter-bit tick; no derived clocks are used.

## Interface
- CLK_FREQ, 50000000, iCLK frequency in Hz
- I2C_FREQ, 20000, SCL frequency in Hz; DIV = CLK_FREQ/(4*I2C_FREQ) iCLK cycles per quarter-bit, DIV ≥ 2 (625 at defaults)

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  reset, asynchronous, active-low
- iDATA  in  24  transaction word: [23:16] slave address incl. R/W=0, [15:8] sub-address, [7:0] data
- iGO  in  1  request; level-sampled only while idle
- oBUSY  out  1  high from acceptance until completion
- oEND  out  1  one-cycle completion pulse
- oNACK  out  1  sticky: at least one byte of the last transaction was not acknowledged
- I2C_SCLK  out  1  SCL, push-pull; single master, no clock stretching
- I2C_SDAT  inout  1  SDA, open-drain: drives 0 or releases (Z)

## Operation
- States: IDLE, START, BIT, STOP, DONE. Every state except IDLE and DONE spans 4 quarters (q0..q3) of DIV cycles each.
- IDLE: SCL=1, SDA released. If iGO=1: latch iDATA into a shift register, clear oNACK, set oBUSY, reset the quarter counter, go to START.
- START: q0 SCL=1 SDA=1; q1–q2 SCL=1 SDA=0; q3 SCL=0 SDA=0. Then go to BIT with index b=0.
- BIT, b = 0..26, 3 bytes × (8 data + 1 ack):
  - Slots 8, 17 and 26 are ack slots; SDA is released there. All other slots drive the shift-register MSB, MSB first.
  - In a data slot, SDA drives 0 when the bit is 0 and releases when it is 1.
  - Quarter levels: q0 SCL=0 and SDA updated; q1 SCL=0; q2–q3 SCL=1.
  - Ack sample: on the last cycle of q2, the synchronised SDA is sampled. A value of 1 sets oNACK.
  - A NACK does not abort the transaction; all 27 slots are completed.
  - After slot 26, q3, go to STOP.
- STOP: q0 SCL=0 SDA=0; q1–q2 SCL=1 SDA=0; q3 SCL=1 SDA released. Then go to DONE.
- DONE: one cycle. oEND=1, oBUSY=0, go to IDLE.
- SDA input passes a 2-flop synchroniser before ack sampling.
- iGO while busy is ignored; iDATA changes after acceptance have no effect.
- If iGO is held high through DONE, the next transaction is accepted on the cycle after DONE.
- Asynchronous reset at any point: state IDLE, SCL=1, SDA released, oBUSY=0, oEND=0, oNACK=0, counters cleared. A partially sent byte is abandoned and no STOP is generated.

## Timing
- Reset values: I2C_SCLK=1, I2C_SDAT=Z, oBUSY=0, oEND=0, oNACK=0.
- All outputs are registered; SDA enable and SCL change only on quarter boundaries.
- Acceptance edge E (iGO=1 in IDLE): oBUSY is high from E; SCL/SDA START pattern begins at E.
- Transaction length: (1+27+1)×4 = 116 quarters = 116×DIV cycles. oEND is high for exactly one cycle starting at E+116×DIV, and oBUSY falls on that same edge.
- Minimum gap between transactions: one IDLE cycle after DONE.
- oNACK is valid when oEND is high and holds until the next acceptance.
- The quarter counter is DIV-1 wide enough; it wraps DIV-1→0 and advances the quarter. Bit index b is 5 bits, 0..26.
- SDA is stable throughout SCL-high quarters except during the START and STOP edges.

## Test plan
- Reset: assert iRST_N=0 with no clock. Required: SCL=1, SDA=Z, oBUSY=0, oEND=0, oNACK=0.
- Nominal write, CLK_FREQ=400, I2C_FREQ=25 (DIV=4), iDATA=24'h729803, slave acks all bytes. Required:
  - START, then bits 0111_0010 / 1001_1000 / 0000_0011 with SDA released in the ack slots, then STOP.
  - oEND is a one-cycle pulse exactly 464 cycles after acceptance; oNACK=0.
- NACK: slave leaves SDA high on the second ack slot. Required: all 27 slots and STOP still generated; oNACK=1 at oEND.
- Busy GO: pulse iGO with iDATA=24'h72FFFF mid-transaction. Required: ignored; the original bytes finish; exactly one oEND.
- Reset mid-byte (slot 12): drop iRST_N. Required: SCL=1 and SDA=Z immediately; the next GO runs a complete clean transaction.
- Back-to-back: hold iGO=1 for 2 transactions. Required: two oEND pulses 465 cycles apart; oNACK cleared at the second acceptance.

Source files
------------

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - I2C write engine for {slave address, sub-address, data}
// Runs on a quarter-bit tick; SDA is open-drain and acks are sampled through a 2-flop synchroniser.
module i2c_write_master #(
   parameter int CLK_FREQ = 50000000,
   parameter int I2C_FREQ = 20000
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic [23:0] iDATA,
   input  logic        iGO,
   output logic        oBUSY,
   output logic        oEND,
   output logic        oNACK,
   output logic        I2C_SCLK,
   inout  wire         I2C_SDAT
);

   localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_BIT, ST_STOP, ST_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [4:0]    bit_q, bit_d;
   logic [23:0]   shreg_q, shreg_d;
   logic          busy_q, busy_d;
   logic          end_q, end_d;
   logic          nack_q, nack_d;
   logic          scl_q, scl_d;
   logic          oe_q, oe_d;
   logic          sda_s1_q, sda_s1_d;
   logic          sda_s2_q, sda_s2_d;
   logic          tick, last_qtr, ack_slot, ack_slot_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      qtr_d    = qtr_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      busy_d   = busy_q;
      end_d    = 1'b0;
      nack_d   = nack_q;
      sda_s1_d = I2C_SDAT;
      sda_s2_d = sda_s1_q;
      tick     = (cnt_q == CNT_MAX);
      last_qtr = tick && (qtr_q == 2'd3);
      ack_slot = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

      if (state_q == ST_START || state_q == ST_BIT || state_q == ST_STOP) begin
         if (tick) begin
            cnt_d = '0;
            qtr_d = qtr_q + 2'd1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      case (state_q)
         // DONE behaves like IDLE for acceptance so a held iGO restarts right after the oEND cycle
         ST_IDLE, ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (iGO) begin
               state_d = ST_START;
               shreg_d = iDATA;
               nack_d  = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               qtr_d   = 2'd0;
               bit_d   = 5'd0;
            end
         end
         ST_START: begin
            if (last_qtr) begin
               state_d = ST_BIT;
               bit_d   = 5'd0;
            end
         end
         ST_BIT: begin
            if (tick && qtr_q == 2'd2 && ack_slot && sda_s2_q)
               nack_d = 1'b1;
            if (last_qtr) begin
               if (!ack_slot)
                  shreg_d = {shreg_q[22:0], 1'b0};
               if (bit_q == 5'd26)
                  state_d = ST_STOP;
               else
                  bit_d = bit_q + 5'd1;
            end
         end
         ST_STOP: begin
            if (last_qtr) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               end_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus levels are derived from the next position so they are registered and move only on quarter boundaries
   always_comb begin
      scl_d      = 1'b1;
      oe_d       = 1'b0;
      ack_slot_d = (bit_d == 5'd8) || (bit_d == 5'd17) || (bit_d == 5'd26);
      case (state_d)
         ST_START: begin
            scl_d = (qtr_d != 2'd3);
            oe_d  = (qtr_d != 2'd0);
         end
         ST_BIT: begin
            scl_d = qtr_d[1];
            oe_d  = ack_slot_d ? 1'b0 : ~shreg_d[23];
         end
         ST_STOP: begin
            scl_d = (qtr_d != 2'd0);
            oe_d  = (qtr_d != 2'd3);
         end
         default: begin
            scl_d = 1'b1;
            oe_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         qtr_q    <= 2'd0;
         bit_q    <= 5'd0;
         shreg_q  <= 24'd0;
         busy_q   <= 1'b0;
         end_q    <= 1'b0;
         nack_q   <= 1'b0;
         scl_q    <= 1'b1;
         oe_q     <= 1'b0;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         qtr_q    <= qtr_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         busy_q   <= busy_d;
         end_q    <= end_d;
         nack_q   <= nack_d;
         scl_q    <= scl_d;
         oe_q     <= oe_d;
         sda_s1_q <= sda_s1_d;
         sda_s2_q <= sda_s2_d;
      end
   end

   assign I2C_SDAT = oe_q ? 1'b0 : 1'bz;
   assign I2C_SCLK = scl_q;
   assign oBUSY    = busy_q;
   assign oEND     = end_q;
   assign oNACK    = nack_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// tb/tb_i2c_write_master.sv - randomized bench for i2c_write_master with a bus-decoding slave model
// The slave decodes START/STOP/bits from sampled SCL/SDA and acks according to a per-byte mask.
module tb_i2c_write_master;

   localparam int DIV = 4;
   localparam int TXN = 116 * DIV;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b1;
   logic        iGO = 1'b0;
   logic [23:0] iDATA = 24'd0;
   logic        oBUSY, oEND, oNACK, I2C_SCLK;
   wire         I2C_SDAT;
   logic        slave_pull = 1'b0;
   bit          clk_en = 1'b0;

   assign I2C_SDAT = slave_pull ? 1'b0 : 1'bz;
   pullup (I2C_SDAT);

   i2c_write_master #(.CLK_FREQ(400), .I2C_FREQ(25)) dut (
      .iCLK     (iCLK),
      .iRST_N   (iRST_N),
      .iDATA    (iDATA),
      .iGO      (iGO),
      .oBUSY    (oBUSY),
      .oEND     (oEND),
      .oNACK    (oNACK),
      .I2C_SCLK (I2C_SCLK),
      .I2C_SDAT (I2C_SDAT)
   );

   always #5 if (clk_en) iCLK = ~iCLK;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bus observer and slave: acks during the clock-low windows following falls 9, 18 and 27
   int       starts, stops, nfall, end_pulses;
   logic     bits[$];
   logic [2:0] nack_mask = 3'b000;
   logic     prev_scl = 1'b1, prev_sda = 1'b1, mon_sda;

   always @(negedge iCLK) begin
      mon_sda = I2C_SDAT;
      if (prev_scl && I2C_SCLK && prev_sda && !mon_sda) starts++;
      if (prev_scl && I2C_SCLK && !prev_sda && mon_sda) stops++;
      if (!prev_scl && I2C_SCLK) bits.push_back(mon_sda);
      if (prev_scl && !I2C_SCLK) nfall++;
      if (oEND) end_pulses++;
      slave_pull = (nfall == 9 && !nack_mask[0]) || (nfall == 18 && !nack_mask[1]) ||
                   (nfall == 27 && !nack_mask[2]);
      prev_scl = I2C_SCLK;
      prev_sda = mon_sda;
   end

   task automatic mon_clear();
      starts = 0;
      stops = 0;
      nfall = 0;
      end_pulses = 0;
      bits.delete();
      slave_pull = 1'b0;
   endtask

   task automatic check_bus(input string tag, input logic [23:0] data, input logic [2:0] mask);
      logic [7:0] b;
      logic       exp_ack;
      check($sformatf("%s.nbits", tag), bits.size(), 28);
      check($sformatf("%s.start", tag), starts, 1);
      check($sformatf("%s.stop", tag), stops, 1);
      for (int i = 0; i < 3; i++) begin
         b = 8'h00;
         for (int j = 0; j < 8; j++)
            b = {b[6:0], (9 * i + j < bits.size()) ? bits[9 * i + j] : 1'bx};
         check($sformatf("%s.byte%0d", tag, i), b, (data >> (16 - 8 * i)) & 24'hFF);
         exp_ack = mask[i];
         check($sformatf("%s.ack%0d", tag, i), (9 * i + 8 < bits.size()) ? bits[9 * i + 8] : 1'bx, exp_ack);
      end
   endtask

   task automatic run_txn(input string tag, input logic [23:0] data, input logic [2:0] mask,
                          input bit busy_go);
      int n, got_end, busy_low;
      logic nack_end;
      @(negedge iCLK);
      mon_clear();
      nack_mask = mask;
      iDATA = data;
      iGO = 1'b1;
      @(posedge iCLK);
      #1;
      iGO = 1'b0;
      iDATA = 24'($urandom);
      n = 0;
      got_end = -1;
      busy_low = 0;
      nack_end = 1'bx;
      while (n < TXN + 16) begin
         @(posedge iCLK);
         n++;
         @(negedge iCLK);
         if (oEND && got_end < 0) begin
            got_end = n;
            nack_end = oNACK;
         end
         if (n < TXN && !oBUSY) busy_low++;
         if (busy_go && n == 200) begin
            iGO = 1'b1;
            iDATA = 24'h72FFFF;
         end
         if (busy_go && n == 201) iGO = 1'b0;
      end
      check($sformatf("%s.latency", tag), got_end, TXN);
      check($sformatf("%s.end_pulses", tag), end_pulses, 1);
      check($sformatf("%s.busy_low", tag), busy_low, 0);
      check($sformatf("%s.nack_at_end", tag), nack_end, |mask);
      check($sformatf("%s.nack_hold", tag), oNACK, |mask);
      check($sformatf("%s.idle_busy", tag), oBUSY, 0);
      check_bus(tag, data, mask);
   endtask

   initial begin
      logic [23:0] d, d2;
      logic [2:0]  m;
      int n, t1, t2;
      logic nack1;

      mon_clear();
      #1 iRST_N = 1'b0;
      #1;
      check("rst.scl", I2C_SCLK, 1);
      check("rst.sda", I2C_SDAT, 1);
      check("rst.busy", oBUSY, 0);
      check("rst.end", oEND, 0);
      check("rst.nack", oNACK, 0);
      clk_en = 1'b1;
      repeat (3) @(negedge iCLK);
      iRST_N = 1'b1;
      repeat (2) @(negedge iCLK);

      run_txn("nominal", 24'h729803, 3'b000, 1'b0);
      run_txn("nack2", 24'h729803, 3'b010, 1'b0);
      run_txn("busygo", 24'hA05A3C, 3'b000, 1'b1);

      // Reset in the middle of slot 12 while SCL is low and SDA is driven low
      d = 24'($urandom) & 24'hFEEFFF;
      @(negedge iCLK);
      mon_clear();
      nack_mask = 3'b001;
      iDATA = d;
      iGO = 1'b1;
      @(posedge iCLK);
      #1 iGO = 1'b0;
      n = 0;
      while (n < 214) begin
         @(posedge iCLK);
         n++;
         @(negedge iCLK);
      end
      check("midrst.pre_nack", oNACK, 1);
      iRST_N = 1'b0;
      #1;
      check("midrst.scl", I2C_SCLK, 1);
      check("midrst.sda", I2C_SDAT, 1);
      check("midrst.busy", oBUSY, 0);
      check("midrst.nack", oNACK, 0);
      repeat (3) @(negedge iCLK);
      check("midrst.end", oEND, 0);
      iRST_N = 1'b1;
      repeat (2) @(negedge iCLK);
      run_txn("after_rst", 24'($urandom) & 24'hFEFFFF, 3'b000, 1'b0);

      // Back-to-back with iGO held high
      d = 24'h5A1234;
      d2 = 24'h90C3E7;
      @(negedge iCLK);
      mon_clear();
      nack_mask = 3'b100;
      iDATA = d;
      iGO = 1'b1;
      @(posedge iCLK);
      #1 iDATA = d2;
      n = 0;
      t1 = -1;
      t2 = -1;
      nack1 = 1'bx;
      while (n < 2 * TXN + 20) begin
         @(posedge iCLK);
         n++;
         @(negedge iCLK);
         if (oEND && t1 < 0) begin
            t1 = n;
            nack1 = oNACK;
            check_bus("b2b1", d, 3'b100);
            mon_clear();
            nack_mask = 3'b000;
         end else if (oEND && t2 < 0) begin
            t2 = n;
            check("b2b.nack2", oNACK, 0);
         end
         if (n == TXN + 1) begin
            check("b2b.reaccept_busy", oBUSY, 1);
            check("b2b.nack_cleared", oNACK, 0);
            iDATA = 24'($urandom);
         end
         if (n == TXN + 2) iGO = 1'b0;
      end
      check("b2b.t1", t1, TXN);
      check("b2b.nack1", nack1, 1);
      check("b2b.gap", t2 - t1, TXN + 1);
      check_bus("b2b2", d2, 3'b000);

      for (int k = 0; k < 6; k++) begin
         d = 24'($urandom) & 24'hFEFFFF;
         m = 3'($urandom_range(0, 7));
         run_txn($sformatf("rand%0d", k), d, m, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
